// File: rtl/servo_pkg.sv
// Shared types, default configuration and arithmetic helpers for the servo frame scheduler.
package servo_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SLEW  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // Width needed to address n channels (never less than one bit).
    function automatic int calc_ch_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Clock cycles per time-base tick.
    function automatic int calc_prescale(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Power-up pulse width: midpoint of the legal range.
    function automatic int calc_center(input int min_us, input int max_us);
        return (min_us + max_us) / 2;
    endfunction

    // Default board configuration.
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_CLK_HZ   = 50_000_000;
    localparam int DEF_TICK_HZ  = 1_000_000;
    localparam int DEF_FRAME_US = 20_000;
    localparam int DEF_MIN_US   = 1_000;
    localparam int DEF_MAX_US   = 2_000;
    localparam int DEF_STEP_US  = 10;

    // Values derived from the default configuration.
    localparam int PRESCALE = calc_prescale(DEF_CLK_HZ, DEF_TICK_HZ);
    localparam int CENTER   = calc_center(DEF_MIN_US, DEF_MAX_US);
    localparam int CH_W     = calc_ch_w(DEF_NUM_CH);

    // Saturate a requested width into [lo, hi].
    function automatic logic [15:0] clamp_range(input logic [15:0] v,
                                                input logic [15:0] lo,
                                                input logic [15:0] hi);
        logic [15:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Move cur toward tgt by at most step.
    function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                                input logic [15:0] tgt,
                                                input logic [15:0] step);
        logic [15:0] r;
        if (tgt > cur) begin
            if ((tgt - cur) > step) begin
                r = cur + step;
            end else begin
                r = tgt;
            end
        end else begin
            if ((cur - tgt) > step) begin
                r = cur - step;
            end else begin
                r = tgt;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_frame_scheduler_if.sv
// Position-write handshake between the board control logic and the frame scheduler.
interface servo_frame_scheduler_if #(
    parameter int CH_W = servo_pkg::CH_W
) ();
    logic            wr_valid;
    logic            wr_ready;
    logic [CH_W-1:0] wr_ch;
    logic [15:0]     wr_pos;

    modport master (output wr_valid, output wr_ch, output wr_pos, input wr_ready);
    modport slave  (input wr_valid, input wr_ch, input wr_pos, output wr_ready);
endinterface

// File: rtl/servo_tick_gen.sv
// Free-running prescaler producing a one-cycle clock enable at the time-base rate.
module servo_tick_gen
    import servo_pkg::*;
#(
    parameter int PRESCALE = servo_pkg::PRESCALE
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == TERM);
    assign tick   = w_term && !clr;

    // Count 0..PRESCALE-1 and wrap; clr parks the counter at zero.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Frame scheduler for NUM_CH hobby servos: one shared time base and frame counter,
// per-frame slew-limited position update, concurrent pulse generation.
module servo_frame_scheduler
    import servo_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int TICK_HZ  = DEF_TICK_HZ,
    parameter int FRAME_US = DEF_FRAME_US,
    parameter int MIN_US   = DEF_MIN_US,
    parameter int MAX_US   = DEF_MAX_US,
    parameter int STEP_US  = DEF_STEP_US
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   enable,
    servo_frame_scheduler_if.slave wr,
    output logic [NUM_CH-1:0]      servo_out,
    output logic                   frame_start,
    output logic [NUM_CH-1:0]      settled
);
    localparam int LP_PRESCALE = calc_prescale(CLK_HZ, TICK_HZ);
    localparam int LP_CENTER   = calc_center(MIN_US, MAX_US);
    localparam int LP_CH_W     = calc_ch_w(NUM_CH);

    localparam logic [15:0] LP_CENTER_V = 16'(LP_CENTER);
    localparam logic [15:0] LP_MIN_V    = 16'(MIN_US);
    localparam logic [15:0] LP_MAX_V    = 16'(MAX_US);
    localparam logic [15:0] LP_STEP_V   = 16'(STEP_US);
    localparam logic [15:0] LP_LAST_FC  = 16'(FRAME_US - 1);

    // Configuration sanity, rejected at elaboration.
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
        $error("servo_frame_scheduler: NUM_CH must be 1..16");
    end
    if (LP_PRESCALE <= NUM_CH + 1) begin : g_bad_prescale
        $error("servo_frame_scheduler: PRESCALE must exceed NUM_CH+1 so slewing ends before the first tick");
    end
    if ((MIN_US > MAX_US) || (MAX_US >= FRAME_US)) begin : g_bad_range
        $error("servo_frame_scheduler: need MIN_US <= MAX_US < FRAME_US");
    end
    if ((FRAME_US > 65536) || (STEP_US < 1)) begin : g_bad_frame
        $error("servo_frame_scheduler: need FRAME_US <= 65536 and STEP_US >= 1");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_frame_cnt;
    logic [LP_CH_W-1:0]   r_idx;
    logic [15:0]          r_cur    [NUM_CH];
    logic [15:0]          r_target [NUM_CH];
    logic [15:0]          r_active [NUM_CH];
    logic [15:0]          w_slew   [NUM_CH];
    logic [NUM_CH-1:0]    r_servo_out;
    logic                 r_frame_start;
    logic                 r_wr_ready;
    logic                 w_tick;
    logic                 w_tick_clr;
    logic                 w_last_ch;
    logic                 w_frame_end;
    logic                 w_wr_fire;
    logic [15:0]          w_wr_pos_clamped;

    // The time base only runs while a frame is live; leaving for IDLE clears it on the same edge.
    assign w_tick_clr = (r_state == ST_IDLE) || !enable;

    servo_tick_gen #(
        .PRESCALE (LP_PRESCALE)
    ) u_tick_gen (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (w_tick_clr),
        .tick   (w_tick)
    );

    assign w_last_ch        = (r_idx == LP_CH_W'(NUM_CH - 1));
    assign w_frame_end      = w_tick && (r_frame_cnt == LP_LAST_FC);
    assign w_wr_fire        = wr.wr_valid && r_wr_ready;
    assign w_wr_pos_clamped = clamp_range(wr.wr_pos, LP_MIN_V, LP_MAX_V);

    assign wr.wr_ready = r_wr_ready;
    assign servo_out   = r_servo_out;
    assign frame_start = r_frame_start;

    // Sequencer state register.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; dropping enable returns to IDLE from anywhere.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SLEW;
                end
            end
            ST_SLEW: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_last_ch) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_SLEW;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_frame_end) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame position in ticks; held at zero outside a live frame.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= 16'd0;
        end else if (w_state_next == ST_IDLE) begin
            r_frame_cnt <= 16'd0;
        end else if (w_frame_end) begin
            r_frame_cnt <= 16'd0;
        end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Channel pointer walks one channel per SLEW cycle and rests at zero otherwise.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (r_state == ST_SLEW) begin
            r_idx <= r_idx + LP_CH_W'(1);
        end else begin
            r_idx <= '0;
        end
    end

    // Slew-limited candidate position for every channel; only the pointed-at one is committed.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_slew[ch] = step_toward(r_cur[ch], r_target[ch], LP_STEP_V);
        end
    end

    // Commit the slewed position and latch it as this frame's pulse width.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_cur[ch]    <= LP_CENTER_V;
                r_active[ch] <= LP_CENTER_V;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ((r_state == ST_SLEW) && (r_idx == LP_CH_W'(ch))) begin
                    r_cur[ch]    <= w_slew[ch];
                    r_active[ch] <= w_slew[ch];
                end
            end
        end
    end

    // Accepted writes update the target; unaddressable channel numbers match nothing.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_target[ch] <= LP_CENTER_V;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_wr_fire && (wr.wr_ch == LP_CH_W'(ch))) begin
                    r_target[ch] <= w_wr_pos_clamped;
                end
            end
        end
    end

    // Registered outputs: pulses, frame marker and write-ready all follow the sequencer.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_servo_out   <= '0;
            r_frame_start <= 1'b0;
            r_wr_ready    <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_servo_out[ch] <= (r_state != ST_IDLE) && (w_state_next != ST_IDLE) &&
                                   (r_frame_cnt < r_active[ch]);
            end
            r_frame_start <= (w_state_next == ST_START);
            r_wr_ready    <= (w_state_next == ST_IDLE) || (w_state_next == ST_RUN);
        end
    end

    // A channel is settled once its slewed position has caught up with its target.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            settled[ch] = (r_cur[ch] == r_target[ch]);
        end
    end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Bench for servo_frame_scheduler: directed scenarios plus random writes, checked against
// a frame-level model of targets and slew-limited positions.
module tb_servo_frame_scheduler;

    localparam int NUM_CH   = 2;
    localparam int CLK_HZ   = 10_000_000;
    localparam int TICK_HZ  = 1_000_000;
    localparam int FRAME_US = 200;
    localparam int MIN_US   = 50;
    localparam int MAX_US   = 150;
    localparam int STEP_US  = 20;
    localparam int PRESC    = CLK_HZ / TICK_HZ;
    localparam int FRAME_CY = FRAME_US * PRESC;

    typedef struct {
        int c;
        int ch;
        int pos;
    } wr_t;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              enable;
    logic [NUM_CH-1:0] servo_out;
    logic              frame_start;
    logic [NUM_CH-1:0] settled;

    int  checks   = 0;
    int  failures = 0;
    int  m_cur [NUM_CH];
    int  m_tgt [NUM_CH];
    int  meas  [NUM_CH];
    wr_t dir_q [$];

    servo_frame_scheduler_if #(.CH_W(1)) wr_if ();

    servo_frame_scheduler #(
        .NUM_CH   (NUM_CH),
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .FRAME_US (FRAME_US),
        .MIN_US   (MIN_US),
        .MAX_US   (MAX_US),
        .STEP_US  (STEP_US)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .enable      (enable),
        .wr          (wr_if),
        .servo_out   (servo_out),
        .frame_start (frame_start),
        .settled     (settled)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Frame boundary: every channel moves at most STEP_US toward its target.
    function automatic void model_frame_start();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cur[ch] = m_cur[ch] + clampi(m_tgt[ch] - m_cur[ch], -STEP_US, STEP_US);
        end
    endfunction

    function automatic void model_write(input int ch, input int pos);
        if (ch < NUM_CH) m_tgt[ch] = clampi(pos, MIN_US, MAX_US);
    endfunction

    function automatic logic [31:0] model_settled();
        logic [31:0] s = '0;
        for (int ch = 0; ch < NUM_CH; ch++) s[ch] = (m_cur[ch] == m_tgt[ch]);
        return s;
    endfunction

    task automatic wait_start(input string tag);
        int n = 0;
        while ((frame_start !== 1'b1) && (n < 3 * FRAME_CY)) begin
            step();
            n++;
        end
        chk(tag, frame_start, 1);
    endtask

    // Runs one full frame starting in the START cycle; ends in the next frame's START cycle.
    task automatic run_frame(input bit hold_start, input int hold_ch, input int hold_pos,
                             input bit rand_wr);
        int hi [NUM_CH];
        int hs = 0;
        bit holding = 1'b0;
        model_frame_start();
        for (int ch = 0; ch < NUM_CH; ch++) hi[ch] = 0;
        for (int c = 0; c < FRAME_CY; c++) begin
            bit exp_rdy = (c >= 3);
            chk("frame_start_level", frame_start, (c == 0) ? 1 : 0);
            chk("wr_ready_level", wr_if.wr_ready, exp_rdy ? 1 : 0);
            if (c == 0) chk("servo_low_in_start", servo_out, 0);
            if (c == FRAME_CY - 1) chk("settled", settled, model_settled());
            for (int ch = 0; ch < NUM_CH; ch++) hi[ch] += servo_out[ch] ? 1 : 0;
            wr_if.wr_valid = 1'b0;
            if (hold_start && (c == 0)) holding = 1'b1;
            if (holding) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_ch    = 1'(hold_ch);
                wr_if.wr_pos   = 16'(hold_pos);
            end else if ((dir_q.size() > 0) && (dir_q[0].c == c)) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_ch    = 1'(dir_q[0].ch);
                wr_if.wr_pos   = 16'(dir_q[0].pos);
                void'(dir_q.pop_front());
            end else if (rand_wr && (c >= 3) && (c < FRAME_CY - 1) &&
                         ($urandom_range(0, 399) == 0)) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_ch    = 1'($urandom_range(0, NUM_CH - 1));
                wr_if.wr_pos   = 16'($urandom_range(0, 300));
            end
            if (wr_if.wr_valid && wr_if.wr_ready) hs++;
            if (wr_if.wr_valid && exp_rdy) begin
                model_write(int'(wr_if.wr_ch), int'(wr_if.wr_pos));
                holding = 1'b0;
            end
            step();
        end
        wr_if.wr_valid = 1'b0;
        chk("frame_period", frame_start, 1);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            chk($sformatf("width_cycles_ch%0d", ch), hi[ch], m_cur[ch] * PRESC);
            meas[ch] = hi[ch];
        end
        if (hold_start) chk("held_write_handshakes", hs, 1);
    endtask

    initial begin
        rst            = 1'b0;
        enable         = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_ch    = 1'b0;
        wr_if.wr_pos   = 16'd0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cur[ch] = (MIN_US + MAX_US) / 2;
            m_tgt[ch] = (MIN_US + MAX_US) / 2;
        end

        // Reset state.
        repeat (3) step();
        chk("rst_servo_out", servo_out, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_wr_ready", wr_if.wr_ready, 0);
        chk("rst_settled", settled, 2'b11);

        // Plain frames at center.
        rst    = 1'b1;
        enable = 1'b1;
        wait_start("first_frame_start");
        repeat (2) run_frame(1'b0, 0, 0, 1'b0);
        chk("center_ch0", meas[0], 1000);
        chk("center_ch1", meas[1], 1000);

        // Slew toward 140 on ch0.
        dir_q.push_back('{100, 0, 140});
        run_frame(1'b0, 0, 0, 1'b0);
        run_frame(1'b0, 0, 0, 1'b0);
        chk("slew_ch0_f1", meas[0], 1200);
        chk("slew_ch1_f1", meas[1], 1000);
        run_frame(1'b0, 0, 0, 1'b0);
        chk("slew_ch0_f2", meas[0], 1400);
        run_frame(1'b0, 0, 0, 1'b0);
        chk("slew_ch0_f3", meas[0], 1400);

        // Two writes to ch1 in one frame: low one clamps, last one (clamped high) wins.
        dir_q.push_back('{200, 1, 10});
        dir_q.push_back('{400, 1, 500});
        run_frame(1'b0, 0, 0, 1'b0);
        run_frame(1'b0, 0, 0, 1'b0);
        chk("clamp_ch1_f1", meas[1], 1200);
        run_frame(1'b0, 0, 0, 1'b0);
        chk("clamp_ch1_f2", meas[1], 1400);
        run_frame(1'b0, 0, 0, 1'b0);
        chk("clamp_ch1_f3", meas[1], 1500);

        // Write held across the frame boundary: accepted once, on the first RUN cycle.
        run_frame(1'b1, 0, 60, 1'b0);
        chk("held_ch0_same_frame", meas[0], 1400);
        run_frame(1'b0, 0, 0, 1'b0);
        chk("held_ch0_next_frame", meas[0], 1200);

        // Random write traffic.
        repeat (4) run_frame(1'b0, 0, 0, 1'b1);

        // Disable mid-pulse, write while idle, re-enable.
        model_frame_start();
        repeat (300) step();
        chk("pre_disable_servo", servo_out, 2'b11);
        enable = 1'b0;
        step();
        chk("disable_servo_low", servo_out, 0);
        chk("disable_ready", wr_if.wr_ready, 1);
        for (int i = 0; i < 20; i++) begin
            chk("idle_servo_low", servo_out, 0);
            chk("idle_no_frame_start", frame_start, 0);
            step();
        end
        wr_if.wr_valid = 1'b1;
        wr_if.wr_ch    = 1'b0;
        wr_if.wr_pos   = 16'd80;
        model_write(0, 80);
        step();
        wr_if.wr_valid = 1'b0;
        enable         = 1'b1;
        step();
        chk("reenable_frame_start", frame_start, 1);
        run_frame(1'b0, 0, 0, 1'b0);
        run_frame(1'b0, 0, 0, 1'b0);

        // Asynchronous reset between clock edges.
        model_frame_start();
        repeat (50) step();
        chk("pre_reset_servo", servo_out, 2'b11);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_servo", servo_out, 0);
        chk("async_rst_frame_start", frame_start, 0);
        chk("async_rst_ready", wr_if.wr_ready, 0);
        chk("async_rst_settled", settled, 2'b11);
        step();
        rst = 1'b1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cur[ch] = (MIN_US + MAX_US) / 2;
            m_tgt[ch] = (MIN_US + MAX_US) / 2;
        end
        wait_start("post_reset_frame_start");
        run_frame(1'b0, 0, 0, 1'b0);
        chk("post_reset_ch0", meas[0], 1000);
        chk("post_reset_ch1", meas[1], 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
